frv_lsu_pipelined: RTL
======================

Name: frv_lsu_pipelined

Overview:
- Parametrised successor to the single-outstanding load/store unit used by the memory stage.
- Issues up to DEPTH outstanding data-memory transactions and tracks them in an in-order tag FIFO.
- Aligns and sign/zero-extends load data and presents one in-order response per retired access to writeback.
- Split request/response memory bus; the pipeline sees a valid/ready request side and a valid/ready response side.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- DEPTH, 4, maximum outstanding transactions; power of two, 1..16.
- TAGW, 5, width of the destination-register tag carried with each request.

Ports:
- g_clk  in  1  global clock, rising edge.
- g_reset  in  1  asynchronous, active-high reset.
- flush  in  1  squash all in-flight accesses.
- hold_lsu_req  in  1  inhibit new dmem requests.
- lsu_valid  in  1  request valid.
- lsu_ready  out  1  request consumed this cycle.
- lsu_addr  in  XLEN  byte address.
- lsu_wdata  in  XLEN  store data, LSB-aligned.
- lsu_load  in  1  load op.
- lsu_store  in  1  store op.
- lsu_width  in  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only).
- lsu_signed  in  1  sign-extend load.
- lsu_tag  in  TAGW  destination register.
- lsu_a_error  out  1  misaligned; combinational, qualified by lsu_valid.
- dmem_req  out  1  request.
- dmem_wen  out  1  write.
- dmem_strb  out  XLEN/8  byte strobe.
- dmem_wdata  out  XLEN  lane-shifted write data.
- dmem_addr  out  XLEN  address, low log2(XLEN/8) bits zeroed.
- dmem_gnt  in  1  request accepted.
- dmem_recv  in  1  response valid.
- dmem_ack  out  1  response accepted.
- dmem_rdata  in  XLEN  raw read data.
- dmem_error  in  1  bus error.
- rsp_valid  out  1  retired access.
- rsp_ready  in  1  writeback accepts.
- rsp_rdata  out  XLEN  extended load data; 0 for stores.
- rsp_tag  out  TAGW  tag.
- rsp_load  out  1  was load.
- rsp_error  out  1  bus error.

Behaviour:
- Reset (async, any cycle including mid-transaction): FIFO pointers/count=0, squash bits clear, rsp_valid=0, all rsp_* regs=0. Combinational outputs follow from the cleared state. Responses arriving after reset from pre-reset requests are the system's responsibility; the bus is reset together with the LSU.
- Misalignment:
  - Half: addr[0]!=0. Word: addr[1:0]!=0. Double: addr[2:0]!=0.
  - lsu_a_error=1 and lsu_ready=1 in the same cycle; no dmem_req, no FIFO push, no response.
- Issue:
  - dmem_req = lsu_valid && (lsu_load||lsu_store) && !lsu_a_error && !full && !hold_lsu_req && !flush.
  - lsu_ready = dmem_req&&dmem_gnt, or the misaligned case.
  - Requester holds inputs stable until lsu_ready.
  - On grant, push {tag, width, signed, addr low bits, load} to the FIFO.
  - Latency: request to earliest response is 1 cycle (dmem_recv the cycle after grant is legal); a grant with dmem_recv and ack in the same cycle is also handled.
- Strobes: byte 1<<a, half 3<<a, word 0xF<<a, double all ones. dmem_wdata = lsu_wdata replicated across lanes.
- Response:
  - dmem_ack = !empty && (head squashed || !rsp_valid || rsp_ready).
  - On dmem_recv&&dmem_ack, pop the head. If not squashed, load rsp_* next cycle: rdata shifted right by head offset*8, masked to width, sign- or zero-extended. rsp_valid holds until rsp_ready.
  - dmem_recv with empty FIFO is a protocol error; ignore it and keep dmem_ack=0.
- Full/empty:
  - full = (count==DEPTH); a push is blocked when full even if a pop occurs the same cycle.
  - Simultaneous push and pop: count unchanged, pointers wrap modulo DEPTH.
- flush:
  - All current FIFO entries get their squash bit set; their responses are acked and dropped.
  - rsp_valid is cleared next cycle.
  - No issue in the flush cycle; issue resumes the next cycle while squashed entries drain.

Optional Feature:
- FRV_LSU_TRACE_EN defined: adds outputs rsp_addr (XLEN) and rsp_wdata (XLEN), stored per FIFO entry and presented with rsp_valid for RVFI-style tracing; both reset to 0.
- Undefined: ports and storage absent; behaviour otherwise identical.

Decomposition:
- Shared package frv_lsu_pkg:
  - width enum (LSU_W_BYTE/HALF/WORD/DBL).
  - tracking-entry struct.
  - strobe and extension functions.
- Sub-module frv_lsu_tag_fifo: parametrised DEPTH×entry FIFO with per-entry squash bits, full/empty, and a flush-mark input.

Test Plan:
- Back-to-back word loads to 0x100, 0x104, 0x108 with gnt=1 and recv 2 cycles later, rdata 0xA,0xB,0xC → three rsp_valid in order, tags preserved, rdata 0xA,0xB,0xC.
- Signed byte load addr 0x203, rdata 0x80000000 → rsp_rdata 0xFFFFFF80; unsigned gives 0x00000080.
- Store half 0xBEEF to 0x102 → dmem_strb 4'b1100, dmem_wdata 0xBEEFBEEF; response rsp_load=0, rsp_rdata=0.
- Word load addr 0x101 → lsu_a_error=1, lsu_ready=1, dmem_req=0 that cycle; no response.
- DEPTH=4, recv withheld, 5 issues → 4 grants, dmem_req=0 on the 5th until one response drains.
- 3 outstanding, flush pulsed, then responses arrive → dmem_ack=1 each time, rsp_valid stays 0; a new load issued after the flush returns normally.

Source files
------------

// File: rtl/frv_lsu_pkg.sv
// Shared types and helpers for the pipelined load/store unit: access width
// encoding, the per-transaction tracking entry, strobe/lane/extension math.
package frv_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_W_BYTE = 2'b00,
        LSU_W_HALF = 2'b01,
        LSU_W_WORD = 2'b10,
        LSU_W_DBL  = 2'b11
    } lsu_width_e;

    // Everything writeback needs to shape the raw read data, minus the tag.
    typedef struct packed {
        lsu_width_e width;
        logic       sgn;
        logic [2:0] off;
        logic       load;
    } lsu_entry_t;

    function automatic logic lsu_misaligned(input lsu_width_e w, input logic [2:0] a);
        logic m;
        case (w)
            LSU_W_HALF: m = a[0];
            LSU_W_WORD: m = |a[1:0];
            LSU_W_DBL:  m = |a;
            default:    m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] lsu_strobe(input lsu_width_e w, input logic [2:0] off);
        logic [7:0] s;
        case (w)
            LSU_W_BYTE: s = 8'h01 << off;
            LSU_W_HALF: s = 8'h03 << off;
            LSU_W_WORD: s = 8'h0F << off;
            default:    s = 8'hFF;
        endcase
        return s;
    endfunction

    // Store data is replicated so every lane carries it; the strobe picks the lane.
    function automatic logic [63:0] lsu_replicate(input logic [63:0] d, input lsu_width_e w);
        logic [63:0] r;
        case (w)
            LSU_W_BYTE: r = {8{d[7:0]}};
            LSU_W_HALF: r = {4{d[15:0]}};
            LSU_W_WORD: r = {2{d[31:0]}};
            default:    r = d;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] lsu_extend(input logic [63:0] raw, input lsu_width_e w,
                                               input logic sgn, input logic [2:0] off);
        logic [63:0] s;
        logic [63:0] r;
        s = raw >> {off, 3'b000};
        case (w)
            LSU_W_BYTE: r = {{56{sgn & s[7]}}, s[7:0]};
            LSU_W_HALF: r = {{48{sgn & s[15]}}, s[15:0]};
            LSU_W_WORD: r = {{32{sgn & s[31]}}, s[31:0]};
            default:    r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/frv_lsu_tag_fifo.sv
// In-order tracking FIFO for outstanding accesses. Each slot carries a squash
// bit; i_flush marks every slot so drained entries are dropped, not retired.
module frv_lsu_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_head,
    output logic          o_head_sq
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_sq;
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // A push is refused while full, even if a pop frees a slot this cycle.
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd];
    assign o_head_sq = r_sq[r_rd];

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_sq    <= '0;
        end else begin
            if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
            if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Free slots get marked too; a later push clears its own bit.
            if (i_flush) r_sq <= '1;
            if (w_push)  r_sq[r_wr] <= 1'b0;
        end
    end

endmodule

// File: rtl/frv_lsu_pipelined.sv
// Pipelined load/store unit: up to DEPTH outstanding dmem accesses, retired in
// order with load alignment/extension. Define FRV_LSU_TRACE_EN for rsp_addr/rsp_wdata.
module frv_lsu_pipelined
    import frv_lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic              flush,
    input  logic              hold_lsu_req,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [XLEN-1:0]   lsu_addr,
    input  logic [XLEN-1:0]   lsu_wdata,
    input  logic              lsu_load,
    input  logic              lsu_store,
    input  logic [1:0]        lsu_width,
    input  logic              lsu_signed,
    input  logic [TAGW-1:0]   lsu_tag,
    output logic              lsu_a_error,
    output logic              dmem_req,
    output logic              dmem_wen,
    output logic [XLEN/8-1:0] dmem_strb,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN-1:0]   dmem_addr,
    input  logic              dmem_gnt,
    input  logic              dmem_recv,
    output logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_error,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [TAGW-1:0]   rsp_tag,
    output logic              rsp_load,
    output logic              rsp_error
`ifdef FRV_LSU_TRACE_EN
   ,output logic [XLEN-1:0]   rsp_addr,
    output logic [XLEN-1:0]   rsp_wdata
`endif
);

    localparam int SW = XLEN / 8;
    localparam int OW = $clog2(SW);
    localparam int EW = $bits(lsu_entry_t);
`ifdef FRV_LSU_TRACE_EN
    localparam int DW = TAGW + EW + 2 * XLEN;
`else
    localparam int DW = TAGW + EW;
`endif

    lsu_width_e    w_width;
    lsu_entry_t    w_entry;
    lsu_entry_t    w_head_entry;
    logic [DW-1:0] w_push_data;
    logic [DW-1:0] w_head_data;
    logic          w_op;
    logic          w_misal;
    logic          w_push;
    logic          w_pop;
    logic          w_keep;
    logic          w_full;
    logic          w_empty;
    logic          w_head_sq;
    logic [XLEN-1:0] w_ext;

    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata;
    logic [TAGW-1:0] r_rsp_tag;
    logic            r_rsp_load;
    logic            r_rsp_error;

    assign w_width = lsu_width_e'(lsu_width);
    assign w_op    = lsu_load || lsu_store;
    assign w_misal = lsu_misaligned(w_width, lsu_addr[2:0]);

    always_comb begin
        w_entry       = '0;
        w_entry.width = w_width;
        w_entry.sgn   = lsu_signed;
        w_entry.off   = 3'(lsu_addr[OW-1:0]);
        w_entry.load  = lsu_load;
    end

    // Handshakes: a request transfers when lsu_valid && lsu_ready (grant, or a
    // misaligned reject), a bus response when dmem_recv && dmem_ack, and a
    // retired access when rsp_valid && rsp_ready; each valid holds until then.
    assign lsu_a_error = lsu_valid && w_op && w_misal;
    assign dmem_req    = lsu_valid && w_op && !w_misal && !w_full && !hold_lsu_req && !flush;
    assign w_push      = dmem_req && dmem_gnt;
    assign lsu_ready   = w_push || lsu_a_error;
    assign dmem_wen    = lsu_store;
    assign dmem_addr   = {lsu_addr[XLEN-1:OW], {OW{1'b0}}};
    assign dmem_strb   = SW'(lsu_strobe(w_width, w_entry.off));
    assign dmem_wdata  = XLEN'(lsu_replicate(64'(lsu_wdata), w_width));

`ifdef FRV_LSU_TRACE_EN
    assign w_push_data = {lsu_addr, lsu_wdata, lsu_tag, w_entry};
`else
    assign w_push_data = {lsu_tag, w_entry};
`endif

    frv_lsu_tag_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .i_clk     (g_clk),
        .i_rst     (g_reset),
        .i_push    (w_push),
        .i_data    (w_push_data),
        .i_pop     (w_pop),
        .i_flush   (flush),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_head    (w_head_data),
        .o_head_sq (w_head_sq)
    );

    // The head popped during a flush cycle is one of the flushed accesses, so it
    // is acked and dropped just like an already-squashed entry.
    assign w_head_entry = lsu_entry_t'(w_head_data[EW-1:0]);
    assign dmem_ack     = !w_empty && (w_head_sq || flush || !r_rsp_valid || rsp_ready);
    assign w_pop        = dmem_recv && dmem_ack;
    assign w_keep       = w_pop && !w_head_sq && !flush;
    assign w_ext        = XLEN'(lsu_extend(64'(dmem_rdata), w_head_entry.width,
                                           w_head_entry.sgn, w_head_entry.off));

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_tag   <= '0;
            r_rsp_load  <= 1'b0;
            r_rsp_error <= 1'b0;
        end else if (flush) begin
            r_rsp_valid <= 1'b0;
        end else if (w_keep) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_head_entry.load ? w_ext : '0;
            r_rsp_tag   <= w_head_data[EW +: TAGW];
            r_rsp_load  <= w_head_entry.load;
            r_rsp_error <= dmem_error;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef FRV_LSU_TRACE_EN
    logic [XLEN-1:0] r_rsp_addr;
    logic [XLEN-1:0] r_rsp_wdata;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_rsp_addr  <= '0;
            r_rsp_wdata <= '0;
        end else if (w_keep) begin
            r_rsp_wdata <= w_head_data[EW + TAGW +: XLEN];
            r_rsp_addr  <= w_head_data[EW + TAGW + XLEN +: XLEN];
        end
    end

    assign rsp_addr  = r_rsp_addr;
    assign rsp_wdata = r_rsp_wdata;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_tag   = r_rsp_tag;
    assign rsp_load  = r_rsp_load;
    assign rsp_error = r_rsp_error;

endmodule
